// File: rtl/fir_mac_controller.sv
// -----------------------------------------------------------------------------
// fir_mac_controller
//   Sequencing FSM for a ROM-less FIR MAC datapath. The datapath is a shift
//   register, a tap counter, a product register and an accumulator register.
//   One sample is accepted per valid/ready handshake. The controller then runs
//   coeff_size MAC cycles and one drain cycle, and presents the result until
//   downstream consumes it.
//
//   Configuration macro: FIR_CTRL_EARLY_ACCEPT_EN
//     defined   : in DONE, in_ready follows out_ready. A consume that coincides
//                 with in_valid starts the next sample directly, so the
//                 back-to-back period is coeff_size+2 cycles.
//     undefined : DONE returns to IDLE on consume. The period is
//                 coeff_size+3 cycles.
// -----------------------------------------------------------------------------
module fir_mac_controller #(
    parameter int coeff_size = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output logic busy,
    input  logic tc,
    output logic input_reset,
    output logic input_enable,
    output logic counter_reset,
    output logic counter_enable,
    output logic multiplier_reset,
    output logic multiplier_enable,
    output logic output_reset,
    output logic output_enable
);

    // The tap counter modulus has to be at least two for MAC/DRAIN to make sense.
    generate
        if (coeff_size < 2) begin : g_bad_coeff_size
            $error("fir_mac_controller: coeff_size must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic accept_s;
    logic in_ready_s;
    logic out_valid_s;
    logic busy_s;
    logic counter_enable_s;
    logic multiplier_enable_s;
    logic output_enable_s;

    // State register: async clear to IDLE; reset also holds it there on each edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-state strobe decode (Moore, plus the accept path).
    always_comb begin
        state_next_s        = state_r;
        accept_s            = 1'b0;
        in_ready_s          = 1'b0;
        out_valid_s         = 1'b0;
        busy_s              = 1'b0;
        counter_enable_s    = 1'b0;
        multiplier_enable_s = 1'b0;
        output_enable_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_MAC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                // The product of tap k is registered as count k is left. The
                // accumulator adds the product from the previous tap.
                busy_s              = 1'b1;
                counter_enable_s    = 1'b1;
                multiplier_enable_s = 1'b1;
                output_enable_s     = 1'b1;
                if (tc) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_MAC;
                end
            end
            ST_DRAIN: begin
                // One more add picks up the product of the last tap.
                busy_s          = 1'b1;
                output_enable_s = 1'b1;
                state_next_s    = ST_DONE;
            end
            ST_DONE: begin
                out_valid_s = 1'b1;
`ifdef FIR_CTRL_EARLY_ACCEPT_EN
                in_ready_s = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept_s     = 1'b1;
                        state_next_s = ST_MAC;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_DONE;
                end
`else
                in_ready_s = 1'b0;
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
`endif
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output drive: while reset is high every datapath register is cleared and
    // all handshakes are low. Otherwise the decoded strobes are driven.
    always_comb begin
        in_ready          = 1'b0;
        out_valid         = 1'b0;
        busy              = 1'b0;
        input_reset       = 1'b0;
        input_enable      = 1'b0;
        counter_reset     = 1'b0;
        counter_enable    = 1'b0;
        multiplier_reset  = 1'b0;
        multiplier_enable = 1'b0;
        output_reset      = 1'b0;
        output_enable     = 1'b0;
        if (reset) begin
            input_reset      = 1'b1;
            counter_reset    = 1'b1;
            multiplier_reset = 1'b1;
            output_reset     = 1'b1;
        end else begin
            in_ready          = in_ready_s;
            out_valid         = out_valid_s;
            busy              = busy_s;
            // The accept loads the new sample and clears the counter, the
            // product and the accumulator. The shift history is kept.
            input_enable      = accept_s;
            counter_reset     = accept_s;
            multiplier_reset  = accept_s;
            output_reset      = accept_s;
            counter_enable    = counter_enable_s;
            multiplier_enable = multiplier_enable_s;
            output_enable     = output_enable_s;
        end
    end

endmodule
